// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: channel state encoding and
// default timing constants (also referenced by the game top).
package btn_pkg;

  // Channel FSM state encoding
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PRESS_DB = 2'd1;
  localparam logic [1:0] S_HELD     = 2'd2;
  localparam logic [1:0] S_REL_DB   = 2'd3;

  // Default timing constants
  localparam int DEF_N_CH          = 4;
  localparam int DEF_DB_CYCLES     = 6000;
  localparam int DEF_REPEAT_DELAY  = 5000000;
  localparam int DEF_REPEAT_PERIOD = 1000000;

  // Larger of two integers, used to size the repeat counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: 2-flop synchroniser, symmetric press/release debounce
// FSM, registered level/press/release outputs.
// Optional hold-to-repeat press pulses when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_chan
  import btn_pkg::*;
#(
  parameter int ACTIVE_LOW    = 1,
  parameter int DB_CYCLES     = DEF_DB_CYCLES
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int DB_W = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            raw_pressed;
  logic [1:0]      sync_q, sync_d;
  logic            key_s;
  logic [1:0]      state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            key_level_q, key_level_d;
  logic            key_press_q, key_press_d;
  logic            key_release_q, key_release_d;
  logic            press_evt, release_evt;

  // Polarity is normalised ahead of the synchroniser so everything downstream
  // works in "1 = pressed" terms and reset loads the not-pressed level.
  assign raw_pressed = (ACTIVE_LOW != 0) ? ~key_raw : key_raw;
  assign key_s       = sync_q[1];

  // Shift the raw level through the two synchroniser stages
  always_comb begin
    sync_d = {sync_q[0], raw_pressed};
  end

  // Debounce FSM: a new level must hold for DB_CYCLES before it is accepted
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    key_level_d = key_level_q;
    press_evt   = 1'b0;
    release_evt = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (key_s) begin
          state_d  = S_PRESS_DB;
          db_cnt_d = '0;
        end
      end
      S_PRESS_DB: begin
        if (!key_s) begin
          state_d  = S_IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = S_HELD;
          db_cnt_d    = '0;
          press_evt   = 1'b1;
          key_level_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      S_HELD: begin
        if (!key_s) begin
          state_d  = S_REL_DB;
          db_cnt_d = '0;
        end
      end
      S_REL_DB: begin
        if (key_s) begin
          state_d  = S_HELD;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = S_IDLE;
          db_cnt_d    = '0;
          release_evt = 1'b1;
          key_level_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RP_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_periodic_q, rpt_periodic_d;
  logic             rpt_fire;

  // Repeat timer runs while the debounced level is high (HELD and REL_DB), so a
  // rejected release glitch keeps the cadence; a release pulse masks a repeat.
  always_comb begin
    rpt_cnt_d      = '0;
    rpt_periodic_d = 1'b0;
    rpt_fire       = 1'b0;
    if ((state_q == S_HELD) || (state_q == S_REL_DB)) begin
      rpt_cnt_d      = rpt_cnt_q + RPT_W'(1);
      rpt_periodic_d = rpt_periodic_q;
      if (rpt_cnt_q == (rpt_periodic_q ? RP_LAST : RD_LAST)) begin
        rpt_cnt_d      = '0;
        rpt_periodic_d = 1'b1;
        rpt_fire       = ~release_evt;
      end
    end
  end

  // Repeat timer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt_q      <= '0;
      rpt_periodic_q <= 1'b0;
    end else begin
      rpt_cnt_q      <= rpt_cnt_d;
      rpt_periodic_q <= rpt_periodic_d;
    end
  end

  // Press output merges the accepted press with repeat pulses
  always_comb begin
    key_press_d   = press_evt | rpt_fire;
    key_release_d = release_evt;
  end
`else
  // Press output is the accepted press only
  always_comb begin
    key_press_d   = press_evt;
    key_release_d = release_evt;
  end
`endif

  // Synchroniser, FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= '0;
      state_q       <= S_IDLE;
      db_cnt_q      <= '0;
      key_level_q   <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      db_cnt_q      <= db_cnt_d;
      key_level_q   <= key_level_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
    end
  end

  assign key_level   = key_level_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;

endmodule

// File: rtl/btn_debounce_array.sv
// N-channel button conditioner for the game inputs: one independent
// btn_debounce_chan per key, outputs concatenated by channel index.
// Define BTN_AUTOREPEAT_EN to enable hold-to-repeat press pulses.
module btn_debounce_array
  import btn_pkg::*;
#(
  parameter int N_CH          = DEF_N_CH,
  parameter int ACTIVE_LOW    = 1,
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] key_raw,
  output logic [N_CH-1:0] key_level,
  output logic [N_CH-1:0] key_press,
  output logic [N_CH-1:0] key_release
);

  // An illegal timing set shows up as this named block in the elaborated tree
  localparam bit CFG_OK = (DB_CYCLES >= 2) && (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);
  if (!CFG_OK) begin : g_illegal_timing_config
  end

  // One fully independent conditioner per channel
  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    btn_debounce_chan #(
      .ACTIVE_LOW    (ACTIVE_LOW),
      .DB_CYCLES     (DB_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_raw     (key_raw[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce_array.sv
// Directed bench for btn_debounce_array (N_CH=4, DB_CYCLES=8, REPEAT_DELAY=40,
// REPEAT_PERIOD=10, active-low keys). Expected values are hand-derived.
module tb_btn_debounce_array;

  localparam int N_CH = 4;
  localparam int DB   = 8;
  localparam int RD   = 40;
  localparam int RP   = 10;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N_CH-1:0] key_raw = '1;
  logic [N_CH-1:0] key_level, key_press, key_release;

  int n_assert = 0;
  int n_fail   = 0;
  int press_cnt [N_CH];
  int rel_cnt   [N_CH];

  btn_debounce_array #(
    .N_CH          (N_CH),
    .ACTIVE_LOW    (1),
    .DB_CYCLES     (DB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_raw     (key_raw),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge, away from output updates
  always @(negedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (key_press[c])   press_cnt[c] = press_cnt[c] + 1;
      if (key_release[c]) rel_cnt[c]   = rel_cnt[c] + 1;
    end
  end

  // Advance n rising edges and settle 1 unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N_CH-1:0] raw);
    key_raw = raw;
  endtask

  task automatic checkOutput(input string tag, input logic [N_CH-1:0] lvl,
                             input logic [N_CH-1:0] prs, input logic [N_CH-1:0] rel);
    n_assert++;
    assert ({key_level, key_press, key_release} === {lvl, prs, rel}) else begin
      n_fail++;
      $error("[TB] FAIL %s: level/press/release observed %h/%h/%h expected %h/%h/%h",
             tag, key_level, key_press, key_release, lvl, prs, rel);
    end
  endtask

  task automatic checkCount(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int p0, r0;
    int pa [N_CH];
    logic [N_CH-1:0] e_lvl, e_prs, e_rel;

    // Reset
    tick(3);
    checkOutput("reset_held", 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;
    tick(3);
    checkOutput("reset_idle", 4'h0, 4'h0, 4'h0);

    // 1: clean press/release on ch0, held 100 cycles
    $display("[TB] step 1: clean press ch0");
    p0 = press_cnt[0]; r0 = rel_cnt[0];
    applyStimulus(4'hE);
    tick(10);
    checkOutput("t1_before_press", 4'h0, 4'h0, 4'h0);
    tick(1);
    checkOutput("t1_press", 4'h1, 4'h1, 4'h0);
    tick(1);
    checkOutput("t1_after_press", 4'h1, 4'h0, 4'h0);
    tick(88);
    checkOutput("t1_held", 4'h1, 4'h0, 4'h0);
    applyStimulus(4'hF);
    tick(10);
    checkOutput("t1_before_release", 4'h1, 4'h0, 4'h0);
    tick(1);
    checkOutput("t1_release", 4'h0, 4'h0, 4'h1);
    tick(1);
    checkOutput("t1_idle", 4'h0, 4'h0, 4'h0);
    checkCount("t1_press_count", press_cnt[0] - p0, AUTO ? 7 : 1);
    checkCount("t1_release_count", rel_cnt[0] - r0, 1);

    // 2: bounce on ch1 (3,5,7 low) then a real 20-cycle press
    $display("[TB] step 2: bounce ch1");
    p0 = press_cnt[1]; r0 = rel_cnt[1];
    applyStimulus(4'hD); tick(3);
    applyStimulus(4'hF); tick(10);
    applyStimulus(4'hD); tick(5);
    applyStimulus(4'hF); tick(10);
    applyStimulus(4'hD); tick(7);
    applyStimulus(4'hF); tick(10);
    checkOutput("t2_after_bounce", 4'h0, 4'h0, 4'h0);
    checkCount("t2_bounce_press_count", press_cnt[1] - p0, 0);
    applyStimulus(4'hD);
    tick(10);
    checkOutput("t2_before_press", 4'h0, 4'h0, 4'h0);
    tick(1);
    checkOutput("t2_press", 4'h2, 4'h2, 4'h0);
    tick(9);
    applyStimulus(4'hF);
    tick(12);
    checkOutput("t2_idle", 4'h0, 4'h0, 4'h0);
    checkCount("t2_press_count", press_cnt[1] - p0, 1);
    checkCount("t2_release_count", rel_cnt[1] - r0, 1);

    // 3: 4-cycle release glitch on held ch2
    $display("[TB] step 3: release glitch ch2");
    p0 = press_cnt[2]; r0 = rel_cnt[2];
    applyStimulus(4'hB);
    tick(11);
    checkOutput("t3_press", 4'h4, 4'h4, 4'h0);
    tick(5);
    applyStimulus(4'hF);
    tick(4);
    checkOutput("t3_during_blip", 4'h4, 4'h0, 4'h0);
    applyStimulus(4'hB);
    tick(12);
    checkOutput("t3_after_blip", 4'h4, 4'h0, 4'h0);
    checkCount("t3_blip_release_count", rel_cnt[2] - r0, 0);
    applyStimulus(4'hF);
    tick(12);
    checkOutput("t3_idle", 4'h0, 4'h0, 4'h0);
    checkCount("t3_press_count", press_cnt[2] - p0, 1);
    checkCount("t3_release_count", rel_cnt[2] - r0, 1);

    // 4: all channels pressed on the same edge
    $display("[TB] step 4: simultaneous press");
    for (int c = 0; c < N_CH; c++) pa[c] = press_cnt[c];
    applyStimulus(4'h0);
    tick(10);
    checkOutput("t4_before_press", 4'h0, 4'h0, 4'h0);
    tick(1);
    checkOutput("t4_press", 4'hF, 4'hF, 4'h0);
    tick(1);
    checkOutput("t4_after_press", 4'hF, 4'h0, 4'h0);
    applyStimulus(4'hF);
    tick(10);
    checkOutput("t4_before_release", 4'hF, 4'h0, 4'h0);
    tick(1);
    checkOutput("t4_release", 4'h0, 4'h0, 4'hF);
    for (int c = 0; c < N_CH; c++)
      checkCount($sformatf("t4_press_count_ch%0d", c), press_cnt[c] - pa[c], 1);

    // 5: reset in PRESS_DB with count 5, key kept held through reset
    $display("[TB] step 5: reset mid-press");
    p0 = press_cnt[0];
    applyStimulus(4'hE);
    tick(8);
    rst_n = 1'b0;
    #2;
    checkOutput("t5_reset_asserted", 4'h0, 4'h0, 4'h0);
    tick(3);
    checkOutput("t5_reset_held", 4'h0, 4'h0, 4'h0);
    checkCount("t5_no_pulse_in_reset", press_cnt[0] - p0, 0);
    rst_n = 1'b1;
    tick(10);
    checkOutput("t5_before_press", 4'h0, 4'h0, 4'h0);
    tick(1);
    checkOutput("t5_press", 4'h1, 4'h1, 4'h0);
    tick(1);
    checkOutput("t5_after_press", 4'h1, 4'h0, 4'h0);
    applyStimulus(4'hF);
    tick(12);
    checkOutput("t5_idle", 4'h0, 4'h0, 4'h0);
    checkCount("t5_press_count", press_cnt[0] - p0, 1);

    // 6: hold ch3 for 100 cycles, cycle-by-cycle check of repeats and release
    $display("[TB] step 6: hold ch3");
    p0 = press_cnt[3];
    applyStimulus(4'h7);
    tick(10);
    checkOutput("t6_before_press", 4'h0, 4'h0, 4'h0);
    tick(1);
    checkOutput("t6_press", 4'h8, 4'h8, 4'h0);
    for (int i = 1; i <= 105; i++) begin
      tick(1);
      e_lvl = (i < 100) ? 4'h8 : 4'h0;
      e_prs = (AUTO && i >= RD && i < 100 && ((i - RD) % RP) == 0) ? 4'h8 : 4'h0;
      e_rel = (i == 100) ? 4'h8 : 4'h0;
      checkOutput($sformatf("t6_cycle%0d", i), e_lvl, e_prs, e_rel);
      if (i == 89) applyStimulus(4'hF);
    end
    checkCount("t6_press_count", press_cnt[3] - p0, AUTO ? 7 : 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
